// File: rtl/time_entry.sv
// Keypad digit-entry front end for the microwave timer.
// Synchronizes the digit pad and the start/stop buttons, collects up to three
// BCD digits as M:SS, loads them into the downstream digit counters with a
// one-cycle active-low strobe, then enables counting until the chain reports zero.
//
// state | meaning
// IDLE  | buffer empty, waiting for the first legal digit
// ENTRY | one to three digits held, waiting for more digits or start
// LOAD  | loadn low for this single cycle, data buses stable
// RUN   | run_en high, buffer frozen until timer_done or stop
module time_entry #(
  parameter int MAX_TENS = 5
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic [9:0] key,
  input  logic       start,
  input  logic       stop_clear,
  input  logic       timer_done,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic       loadn,
  output logic       run_en,
  output logic [1:0] digit_cnt,
  output logic       err
);

  typedef enum logic [1:0] {IDLE, ENTRY, LOAD, RUN} state_t;

  localparam logic [3:0] MAX_T = 4'(MAX_TENS);

  state_t     state, state_nx;
  logic [9:0] key_s1, key_s2, key_s3;
  logic       start_s1, start_s2, start_s3;
  logic       stop_s1, stop_s2, stop_s3;

  logic [3:0] sec_ones_nx, sec_tens_nx, min_ones_nx;
  logic [1:0] digit_cnt_nx;
  logic       loadn_nx, run_en_nx, err_nx;

  logic       key_ev, key_legal, start_ev, stop_ev;
  logic [3:0] key_dig;

  // Two-flop synchronizers plus a history flop for press/edge detection
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      key_s1   <= '0;
      key_s2   <= '0;
      key_s3   <= '0;
      start_s1 <= 1'b0;
      start_s2 <= 1'b0;
      start_s3 <= 1'b0;
      stop_s1  <= 1'b0;
      stop_s2  <= 1'b0;
      stop_s3  <= 1'b0;
    end else begin
      key_s1   <= key;
      key_s2   <= key_s1;
      key_s3   <= key_s2;
      start_s1 <= start;
      start_s2 <= start_s1;
      start_s3 <= start_s2;
      stop_s1  <= stop_clear;
      stop_s2  <= stop_s1;
      stop_s3  <= stop_s2;
    end
  end

  // A new press needs all keys released first, so a held key yields one event
  assign key_ev    = (key_s2 != '0) && (key_s3 == '0);
  assign key_legal = $onehot(key_s2);
  assign start_ev  = start_s2 & ~start_s3;
  assign stop_ev   = stop_s2 & ~stop_s3;

  // Encode the single pressed key line into its BCD digit
  always_comb begin
    key_dig = '0;
    for (int i = 0; i < 10; i++) begin
      if (key_s2[i]) key_dig = 4'(i);
    end
  end

  // Next state, next digit buffer and next strobe values
  always_comb begin
    state_nx     = state;
    sec_ones_nx  = sec_ones;
    sec_tens_nx  = sec_tens;
    min_ones_nx  = min_ones;
    digit_cnt_nx = digit_cnt;
    loadn_nx     = 1'b1;
    run_en_nx    = 1'b0;
    err_nx       = 1'b0;

    if (stop_ev) begin
      state_nx     = IDLE;
      sec_ones_nx  = '0;
      sec_tens_nx  = '0;
      min_ones_nx  = '0;
      digit_cnt_nx = '0;
    end else begin
      case (state)
        IDLE: begin
          if (key_ev) begin
            if (key_legal) begin
              state_nx     = ENTRY;
              min_ones_nx  = sec_tens;
              sec_tens_nx  = sec_ones;
              sec_ones_nx  = key_dig;
              digit_cnt_nx = 2'd1;
            end else begin
              err_nx = 1'b1;
            end
          end
        end
        ENTRY: begin
          // Start takes precedence over a key event in the same cycle
          if (start_ev) begin
            if (sec_tens > MAX_T) begin
              sec_tens_nx = MAX_T;
              sec_ones_nx = 4'd9;
            end
            state_nx = LOAD;
            loadn_nx = 1'b0;
          end else if (key_ev) begin
            if (!key_legal) begin
              err_nx = 1'b1;
            end else if (digit_cnt != 2'd3) begin
              min_ones_nx  = sec_tens;
              sec_tens_nx  = sec_ones;
              sec_ones_nx  = key_dig;
              digit_cnt_nx = digit_cnt + 2'd1;
            end
          end
        end
        LOAD: begin
          state_nx  = RUN;
          run_en_nx = 1'b1;
        end
        RUN: begin
          if (timer_done) begin
            state_nx     = IDLE;
            sec_ones_nx  = '0;
            sec_tens_nx  = '0;
            min_ones_nx  = '0;
            digit_cnt_nx = '0;
          end else begin
            run_en_nx = 1'b1;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // State and registered outputs; loadn comes straight from a flop
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state     <= IDLE;
      sec_ones  <= '0;
      sec_tens  <= '0;
      min_ones  <= '0;
      digit_cnt <= '0;
      loadn     <= 1'b1;
      run_en    <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nx;
      sec_ones  <= sec_ones_nx;
      sec_tens  <= sec_tens_nx;
      min_ones  <= min_ones_nx;
      digit_cnt <= digit_cnt_nx;
      loadn     <= loadn_nx;
      run_en    <= run_en_nx;
      err       <= err_nx;
    end
  end

endmodule

// File: tb/tb_time_entry.sv
// Bench for time_entry: operation-level model (digit queue, running flag)
// driven by directed scenarios followed by random operation sequences.
module tb_time_entry;

  localparam int MAX_TENS = 5;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic [9:0] key = '0;
  logic       start = 1'b0;
  logic       stop_clear = 1'b0;
  logic       timer_done = 1'b0;
  logic [3:0] sec_ones, sec_tens, min_ones;
  logic       loadn, run_en, err;
  logic [1:0] digit_cnt;

  time_entry #(.MAX_TENS(MAX_TENS)) dut (
    .clk(clk), .clrn(clrn), .key(key), .start(start), .stop_clear(stop_clear),
    .timer_done(timer_done), .sec_ones(sec_ones), .sec_tens(sec_tens),
    .min_ones(min_ones), .loadn(loadn), .run_en(run_en), .digit_cnt(digit_cnt),
    .err(err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model
  int q[$];
  bit running = 0;
  int exp_err, exp_load, exp_load_val;

  // pulse monitor (cumulative counts; tasks take differences)
  int err_seen = 0;
  int lo_seen  = 0;
  int load_val = 0;

  always @(negedge clk) begin
    if (clrn) begin
      if (err) err_seen++;
      if (!loadn) begin
        lo_seen++;
        load_val = {20'd0, min_ones, sec_tens, sec_ones};
      end
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int m_o();
    return (q.size() > 0) ? q[q.size()-1] : 0;
  endfunction
  function automatic int m_t();
    return (q.size() > 1) ? q[q.size()-2] : 0;
  endfunction
  function automatic int m_m();
    return (q.size() > 2) ? q[q.size()-3] : 0;
  endfunction

  task automatic verify(input string op, input int e0, input int l0);
    chk({op, ":sec_ones"}, int'(sec_ones), m_o());
    chk({op, ":sec_tens"}, int'(sec_tens), m_t());
    chk({op, ":min_ones"}, int'(min_ones), m_m());
    chk({op, ":digit_cnt"}, int'(digit_cnt), q.size());
    chk({op, ":run_en"}, int'(run_en), int'(running));
    chk({op, ":err_pulses"}, err_seen - e0, exp_err);
    chk({op, ":load_pulses"}, lo_seen - l0, exp_load);
    if (exp_load != 0) chk({op, ":load_data"}, load_val, exp_load_val);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [9:0] k, input int hold);
    int e0, l0;
    e0 = err_seen; l0 = lo_seen;
    exp_err = 0; exp_load = 0;
    if (!running) begin
      if ($countones(k) > 1) exp_err = 1;
      else if (q.size() < 3) begin
        for (int i = 0; i < 10; i++) if (k[i]) q.push_back(i);
      end
    end
    key = k;
    cyc(hold);
    key = '0;
    cyc(hold);
    verify("press", e0, l0);
  endtask

  task automatic do_start(input int hold);
    int e0, l0;
    e0 = err_seen; l0 = lo_seen;
    exp_err = 0; exp_load = 0;
    if (!running && q.size() > 0) begin
      if (m_t() > MAX_TENS) begin
        q[q.size()-2] = MAX_TENS;
        q[q.size()-1] = 9;
      end
      exp_load = 1;
      exp_load_val = (m_m() << 8) | (m_t() << 4) | m_o();
      running = 1;
    end
    start = 1'b1;
    cyc(hold);
    start = 1'b0;
    cyc(hold);
    verify("start", e0, l0);
  endtask

  task automatic do_done();
    int e0, l0;
    e0 = err_seen; l0 = lo_seen;
    exp_err = 0; exp_load = 0;
    if (running) begin
      q.delete();
      running = 0;
    end
    timer_done = 1'b1;
    cyc(1);
    timer_done = 1'b0;
    cyc(3);
    verify("done", e0, l0);
  endtask

  // stop_clear, optionally with a coincident timer_done pulse
  task automatic do_stop(input bit with_done);
    int e0, l0;
    e0 = err_seen; l0 = lo_seen;
    exp_err = 0; exp_load = 0;
    q.delete();
    running = 0;
    stop_clear = 1'b1;
    timer_done = with_done;
    cyc(1);
    timer_done = 1'b0;
    cyc(2);
    stop_clear = 1'b0;
    cyc(4);
    verify("stop", e0, l0);
  endtask

  initial begin
    int op;
    logic [9:0] k;

    // reset state
    cyc(1);
    chk("rst:sec_ones", int'(sec_ones), 0);
    chk("rst:loadn", int'(loadn), 1);
    chk("rst:run_en", int'(run_en), 0);
    chk("rst:err", int'(err), 0);
    chk("rst:digit_cnt", int'(digit_cnt), 0);
    clrn = 1'b1;
    cyc(2);

    // capture latency: stable before edge N, in buffer after edge N+2
    key = 10'b0000000010;
    cyc(1);
    cyc(1);
    chk("lat_early", int'(sec_ones), 0);
    cyc(1);
    chk("lat_capture", int'(sec_ones), 1);
    q.push_back(1);
    key = '0;
    cyc(4);

    // 1, 3, 0, start -> 1:30
    press(10'b0000001000, 4);
    press(10'b0000000001, 4);
    do_start(4);
    do_done();

    // 8, 7, start -> saturates to 0:59
    press(10'b0100000000, 4);
    press(10'b0010000000, 4);
    chk("two_digits_cnt", int'(digit_cnt), 2);
    do_start(4);
    do_stop(0);

    // 1,2,3,4 -> fourth ignored; then illegal multi-key
    press(10'b0000000010, 4);
    press(10'b0000000100, 4);
    press(10'b0000001000, 4);
    press(10'b0000010000, 4);
    press(10'b0000010100, 4);
    do_start(4);

    // inputs ignored in RUN, then done
    press(10'b0000100000, 4);
    do_start(4);
    do_done();

    // stop together with done in RUN; start on empty buffer
    press(10'b1000000000, 4);
    do_start(4);
    do_stop(1);
    do_start(4);

    // async reset in RUN
    press(10'b0000000100, 4);
    do_start(4);
    @(posedge clk);
    #2 clrn = 1'b0;
    #1;
    chk("async_rst:run_en", int'(run_en), 0);
    chk("async_rst:loadn", int'(loadn), 1);
    chk("async_rst:sec_ones", int'(sec_ones), 0);
    chk("async_rst:digit_cnt", int'(digit_cnt), 0);
    q.delete();
    running = 0;
    cyc(2);
    clrn = 1'b1;
    cyc(2);

    // random operation sequences
    for (int n = 0; n < 250; n++) begin
      op = $urandom_range(0, 99);
      if (op < 50) begin
        k = '0;
        k[$urandom_range(0, 9)] = 1'b1;
        press(k, $urandom_range(4, 6));
      end else if (op < 60) begin
        k = 10'($urandom_range(1, 1023));
        if ($countones(k) < 2) k = k | 10'b1000000001;
        press(k, $urandom_range(4, 6));
      end else if (op < 77) begin
        do_start($urandom_range(4, 6));
      end else if (op < 85) begin
        do_stop(1'($urandom_range(0, 1)));
      end else begin
        do_done();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
